// File: rtl/lfsr_descrambler_rx_if.sv
// Register bus plus input/output beat streams
// for the receive-side LFSR descrambler.
interface lfsr_descrambler_rx_if #(
  parameter int DATA_WIDTH = 11
);
  logic                  write;
  logic [11:0]           addr;
  logic [31:0]           lfsrdin;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  armed;
  logic                  seed_err;

  modport master (
    output write, addr, lfsrdin,
    output s_valid, s_data, s_last,
    output m_ready,
    input  s_ready, m_valid, m_data,
    input  m_last, armed, seed_err
  );

  modport slave (
    input  write, addr, lfsrdin,
    input  s_valid, s_data, s_last,
    input  m_ready,
    output s_ready, m_valid, m_data,
    output m_last, armed, seed_err
  );
endinterface

// File: rtl/lfsr_descrambler_rx.sv
// Receive descrambler: regenerates the 285-bit LFSR
// keystream from a seed and restarts it every frame.
module lfsr_descrambler_rx #(
  parameter int POLY_WIDTH = 285,
  parameter int DATA_WIDTH = 11
) (
  input logic clk,
  input logic rst,
  lfsr_descrambler_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [POLY_WIDTH-1:0] seed;
  logic [POLY_WIDTH-1:0] st;
  logic [POLY_WIDTH-1:0] st_adv;
  logic [DATA_WIDTH-1:0] ks;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic m_valid_q;
  logic m_last_q;
  logic seed_err_q;
  logic ctrl_wr;
  logic arm_req;
  logic disarm;
  logic arm_take;
  logic seed_zero;
  logic accept;
  logic s_ready_c;

  function automatic logic [POLY_WIDTH-1:0] step(
    input logic [POLY_WIDTH-1:0] s
  );
    logic n;
    n = s[284];
    return {s[283:269], n ^ s[268],
            s[267:255], n ^ s[254],
            s[253:222], n ^ s[221],
            s[220:188], n ^ s[187],
            s[186:129], n ^ s[128],
            s[127:0],   n};
  endfunction

  assign ctrl_wr   = bus.write && (bus.addr == 12'h0AA);
  assign disarm    = ctrl_wr && bus.lfsrdin[1];
  assign arm_req   = ctrl_wr && bus.lfsrdin[0]
                   && !bus.lfsrdin[1];
  assign arm_take  = arm_req && (state != RUN);
  assign seed_zero = (seed == '0);
  assign accept    = bus.s_valid && s_ready_c;

  // Keystream bit j is the MSB before step j.
  always_comb begin
    logic [POLY_WIDTH-1:0] s_w;
    s_w = st;
    ks  = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      ks[j] = s_w[284];
      s_w   = step(s_w);
    end
    st_adv = s_w;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (disarm)
      state_nxt = IDLE;
    else if (arm_take)
      state_nxt = seed_zero ? IDLE : ARMED;
    else if (accept)
      state_nxt = bus.s_last ? ARMED : RUN;
  end

  always_comb begin
    bus.armed = (state != IDLE);
    s_ready_c = (state != IDLE)
              && (!m_valid_q || bus.m_ready);
    bus.s_ready = s_ready_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seed <= '0;
    end else if (bus.write) begin
      for (int k = 0; k < 8; k++)
        if (bus.addr == 12'(12'h0A1 + k))
          seed[32*k +: 32] <= bus.lfsrdin;
      if (bus.addr == 12'h0A9)
        seed[284:256] <= bus.lfsrdin[28:0];
    end
  end

  // Frame end reloads the shadow seed as it stood before this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= '0;
      seed_err_q <= 1'b0;
    end else if (!disarm) begin
      if (arm_take) begin
        seed_err_q <= seed_zero;
        if (!seed_zero) st <= seed;
      end else if (accept) begin
        st <= bus.s_last ? seed : st_adv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (disarm) begin
      m_valid_q <= 1'b0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= bus.s_data ^ ks;
      m_last_q  <= bus.s_last;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_last   = m_last_q;
  assign bus.seed_err = seed_err_q;

endmodule

// File: doc/lfsr_descrambler_rx.md
# lfsr_descrambler_rx

Receive-side counterpart of the transmit scrambler's 285-bit primary LFSR. It holds a seed that software writes over the 32-bit register bus into its own address window. It regenerates the identical keystream and XORs it onto an incoming valid/ready data stream, DATA_WIDTH bits per beat. It restarts from the seed at every frame boundary so that it stays aligned with the transmitter.

## Interface
- POLY_WIDTH, 285: LFSR length. Taps are fixed for 285 and the block is only legal at 285.
- DATA_WIDTH, 11: bits per beat, equal to LFSR steps per accepted beat. Legal range 1..32.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset. Synchronous, active-low: sampled on the clk rising edge, asserted when 0.
- write  in  1  register write strobe.
- addr  in  12  register address.
- lfsrdin  in  32  register write data.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  DATA_WIDTH  scrambled data. Bit 0 is the earliest bit.
- s_last  in  1  last beat of frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  descrambled data.
- m_last  out  1  registered copy of s_last.
- armed  out  1  state is ARMED or RUN.
- seed_err  out  1  sticky flag: arm was attempted with an all-zero seed.

## Operation
- Seed shadow register `seed[284:0]`:
  - Addresses 0x0A1..0x0A8 write `seed[32k+31:32k]` for k = 0..7.
  - Address 0x0A9 writes `seed[284:256]` from `lfsrdin[28:0]`.
  - Seed writes are accepted in any state and never disturb the working LFSR `st`.
- Control register at 0x0AA, write-only, one-shot:
  - bit0 ARM: `st <= seed` and the block enters ARMED. It is taken only in IDLE or ARMED and is ignored in RUN.
  - ARM with `seed == 0` is refused: the block stays in or goes to IDLE and `seed_err` is set.
  - bit1 DISARM: taken in any state. The block goes to IDLE, `m_valid` clears and any pending output is dropped.
  - bit1 has priority over bit0.
  - `seed_err` clears only on a successful ARM or on reset.
- One LFSR step, where n = s[284] is the feedback bit:
  - next = {s[283:269], n^s[268], s[267:255], n^s[254], s[253:222], n^s[221], s[220:188], n^s[187], s[186:129], n^s[128], s[127:0], n}.
  - The keystream bit for a step is s[284] before that step is applied.
- Per accepted beat: `ks[j]` is s[284] after j steps from `st`, for j = 0..DATA_WIDTH-1.
  - `m_data <= s_data ^ ks`.
  - `st` advances DATA_WIDTH steps.
- State machine:
  - IDLE: `s_ready = 0`. Goes to ARMED on a successful ARM.
  - ARMED: waiting for the first beat of a frame. An accepted beat with `s_last = 0` goes to RUN. An accepted beat with `s_last = 1` stays in ARMED with `st <= seed`.
  - RUN: an accepted beat with `s_last = 1` goes to ARMED and sets `st <= seed`, which reloads the current shadow value including any seed written mid-frame. Otherwise it stays in RUN and advances.
- `s_ready = (ARMED | RUN) & (!m_valid | m_ready)`. This gives a single output register with no bubbles at full rate.

## Timing
- Reset values: `m_valid = 0`, `m_data = 0`, `m_last = 0`, `armed = 0`, `seed_err = 0`, `s_ready = 0`. Internally `seed = 0`, `st = 0`, state IDLE.
- Latency from an accepted input beat to `m_valid` is 1 cycle. Throughput is 1 beat per cycle.
- `m_data` and `m_last` are held stable while `m_valid & !m_ready`.
- A register write in cycle t takes effect at the edge ending cycle t.
  - ARM in cycle t: `s_ready` can be 1 in cycle t+1.
  - Any beat accepted in the same cycle as a control write is processed with the pre-write state, except DISARM: with DISARM the beat is dropped.
- ARM and a seed word write in the same cycle cannot occur, because they use different addresses.
- Reset asserted mid-frame: all state returns to reset values on the next edge and the output beat is lost.

## Test plan
- Seed = bit 284 only (0x0A9 ← 0x1000_0000, other words 0), ARM, then three beats with `s_data = 0` and m_ready held high -> m_data = 11'h001, 11'h020, 11'h500, each 1 cycle after acceptance.
- Scramble a 10-beat random frame with the same seed in the bench model, then feed it in with the last beat flagged -> plaintext recovered exactly. A second frame restarts at beat 1 with 11'h001 for zero input.
- `m_ready` toggled randomly at 50% -> no beat lost or duplicated, `m_data` stable while stalled, `s_ready` matches the formula.
- ARM with all-zero seed -> seed_err = 1, armed = 0, s_ready = 0. Then write a nonzero seed and ARM -> seed_err = 0, armed = 1.
- DISARM mid-frame with m_valid = 1 -> next cycle m_valid = 0, armed = 0, and an ARM issued in RUN is ignored.
- Rewrite the seed mid-frame -> the current frame is unaffected, and the next frame uses the new seed.
